// File: rtl/wave_pkg.sv
// Shared sample/step types and constants for the waveform output stage.
package wave_pkg;

  localparam int unsigned SAMPLE_W  = 4;
  localparam int unsigned PWM_STEPS = 16;
  localparam int unsigned STEP_W    = $clog2(PWM_STEPS);

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [STEP_W-1:0]   step_t;

  localparam step_t STEP_LAST = step_t'(PWM_STEPS - 1);

endpackage

// File: rtl/wave_tick_div.sv
// Clock divider producing one PWM step tick every DIV enabled clocks.
module wave_tick_div #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;

  assign tick = enable && (div_cnt_q == CNT_LAST);

  // Counter is held at zero while disabled so re-enable starts a clean step.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (!enable || tick) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/wave_pwm_dac.sv
// 16-step PWM DAC with a one-entry pending sample buffer and underrun status.
module wave_pwm_dac
  import wave_pkg::*;
#(
  parameter int unsigned DIV    = 1,
  parameter int unsigned UCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [3:0]        sample_data,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              pwm_out,
  output logic              period_start,
  output logic              underrun,
  output logic [UCNT_W-1:0] underrun_count
);

  localparam logic [UCNT_W-1:0] UCNT_MAX = {UCNT_W{1'b1}};

  logic tick;

  wave_tick_div #(.DIV(DIV)) u_tick_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .tick   (tick)
  );

  step_t             step_q, step_d;
  sample_t           active_q, active_d;
  sample_t           pending_q, pending_d;
  logic              pending_full_q, pending_full_d;
  logic              pwm_q, pwm_d;
  logic              period_start_q, period_start_d;
  logic              underrun_q, underrun_d;
  logic [UCNT_W-1:0] ucnt_q, ucnt_d;

  logic accept;
  logic period_end;

  assign sample_ready = !pending_full_q;
  assign accept       = sample_valid && !pending_full_q;
  assign period_end   = tick && (step_q == STEP_LAST);

  // Buffer accept and active reload are exclusive: accept needs pending empty, reload needs it full.
  always_comb begin
    step_d         = step_q;
    active_d       = active_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    ucnt_d         = ucnt_q;
    period_start_d = period_end;
    underrun_d     = 1'b0;

    if (!enable) begin
      step_d = '0;
    end else if (tick) begin
      step_d = step_q + step_t'(1);
    end

    if (period_end) begin
      if (pending_full_q) begin
        active_d       = pending_q;
        pending_full_d = 1'b0;
      end else begin
        underrun_d = 1'b1;
        if (ucnt_q != UCNT_MAX) begin
          ucnt_d = ucnt_q + UCNT_W'(1);
        end
      end
    end

    if (accept) begin
      pending_d      = sample_t'(sample_data);
      pending_full_d = 1'b1;
    end

    pwm_d = enable && (step_d < active_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q         <= '0;
      active_q       <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
      underrun_q     <= 1'b0;
      ucnt_q         <= '0;
    end else begin
      step_q         <= step_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
      underrun_q     <= underrun_d;
      ucnt_q         <= ucnt_d;
    end
  end

  assign pwm_out        = pwm_q;
  assign period_start   = period_start_q;
  assign underrun       = underrun_q;
  assign underrun_count = ucnt_q;

endmodule
